// File: rtl/rng_request_arbiter.sv
// Round-robin arbiter that hands out one freshness-gated LFSR word at a time,
// reduced to each requester's [0, bound) range by masked rejection sampling.
module rng_request_arbiter #(
    parameter int N   = 3,
    parameter int GAP = 16,
    parameter int W   = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [15:0]    rng,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] bound,
    output logic [N-1:0]   valid,
    output logic [W-1:0]   value,
    output logic           busy
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [7:0] GAP_C = 8'(GAP);

    typedef enum logic {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [IW-1:0]  ptr_q, ptr_d;
    logic [IW-1:0]  owner_q, owner_d;
    logic [7:0]     cnt_q, cnt_d;
    logic [W-1:0]   bnd_q, bnd_d;
    logic [N-1:0]   valid_q, valid_d;
    logic [W-1:0]   value_q, value_d;
    logic           busy_q, busy_d;

    logic [IW-1:0]  order_s [N];
    logic           grant_found_s;
    logic [IW-1:0]  grant_idx_s;
    logic [7:0]     cnt_inc_s;
    logic           fresh_s;
    logic [W-1:0]   mask_s;
    logic [W-1:0]   cand_s;
    logic           accept_s;
    logic [IW-1:0]  next_ptr_s;

    // Smallest all-ones mask covering bound-1; a zero bound selects the full range.
    function automatic logic [W-1:0] range_mask(input logic [W-1:0] b);
        logic [W-1:0] m;
        if (b == {W{1'b0}}) begin
            m = {W{1'b1}};
        end else begin
            m = b - W'(1);
            for (int s = 1; s < W; s = s * 2) begin
                m = m | (m >> s);
            end
        end
        return m;
    endfunction

    // Requester indices in priority order, starting at the round-robin pointer.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            order_s[i] = IW'((int'(ptr_q) + i) % N);
        end
    end

    // First requesting index in priority order; later loop passes win, so scan backwards.
    always_comb begin
        grant_found_s = 1'b0;
        grant_idx_s   = {IW{1'b0}};
        for (int i = N - 1; i >= 0; i--) begin
            if (req[order_s[i]]) begin
                grant_found_s = 1'b1;
                grant_idx_s   = order_s[i];
            end else begin
                grant_found_s = grant_found_s;
                grant_idx_s   = grant_idx_s;
            end
        end
    end

    // Freshness: the word is usable once this edge completes GAP shifts since the last consumption.
    always_comb begin
        if (cnt_q >= GAP_C) begin
            cnt_inc_s = GAP_C;
        end else begin
            cnt_inc_s = cnt_q + 8'd1;
        end
        fresh_s = (cnt_inc_s == GAP_C);
    end

    // Candidate draw, acceptance test and wrap-around successor of the owner.
    always_comb begin
        mask_s   = range_mask(bnd_q);
        cand_s   = rng[W-1:0] & mask_s;
        accept_s = (bnd_q == {W{1'b0}}) || (cand_s < bnd_q);
        if (owner_q == IW'(N - 1)) begin
            next_ptr_s = {IW{1'b0}};
        end else begin
            next_ptr_s = owner_q + IW'(1);
        end
    end

    // Next-state logic: abandon beats consumption; rejection keeps serving the same owner.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        bnd_d   = bnd_q;
        cnt_d   = cnt_inc_s;
        valid_d = {N{1'b0}};
        value_d = {W{1'b0}};
        case (state_q)
            IDLE: begin
                if (grant_found_s) begin
                    state_d = SERVE;
                    owner_d = grant_idx_s;
                    bnd_d   = bound[grant_idx_s * W +: W];
                end else begin
                    state_d = IDLE;
                end
            end
            SERVE: begin
                if (!req[owner_q]) begin
                    state_d = IDLE;
                end else if (!fresh_s) begin
                    state_d = SERVE;
                end else begin
                    cnt_d = 8'd0;
                    if (accept_s) begin
                        valid_d[owner_q] = 1'b1;
                        value_d          = cand_s;
                        ptr_d            = next_ptr_s;
                        state_d          = IDLE;
                    end else begin
                        state_d = SERVE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == SERVE);
    end

    // State and registered outputs; reset clears everything without waiting for a clock.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            ptr_q   <= {IW{1'b0}};
            owner_q <= {IW{1'b0}};
            cnt_q   <= 8'd0;
            bnd_q   <= {W{1'b0}};
            valid_q <= {N{1'b0}};
            value_q <= {W{1'b0}};
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            bnd_q   <= bnd_d;
            valid_q <= valid_d;
            value_q <= value_d;
            busy_q  <= busy_d;
        end
    end

    assign valid = valid_q;
    assign value = value_q;
    assign busy  = busy_q;

endmodule

// File: doc/rng_request_arbiter.md
# rng_request_arbiter

Shares one free-running 16-bit LFSR output among N game requesters (opponent generator, hit-rate roller, level generator). Requesters are granted round-robin. A rng word is consumed only after the LFSR has shifted at least GAP times since the previous consumption, so no two requesters receive correlated bits. Each draw is reduced to a requester-supplied range [0, bound) by masked rejection sampling. The block sits between the LFSR and the game-logic FSMs.

## Interface
- N, default 3: number of requesters.
- GAP, default 16: minimum clock edges between consecutive rng consumptions, range 1..255.
- W, default 8: result and bound width, W ≤ 16.

- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low. 0 clears all state immediately; release is synchronous to clk.
- rng  in  16  LFSR output. The bench may drive it directly.
- req  in  N  per-requester request level. Held until the matching valid bit or until the requester abandons.
- bound  in  N*W  per-requester range. Slice i is bits [i*W +: W]. 0 means full range 2^W.
- valid  out  N  one-hot pulse, one cycle. The result for that requester is on value.
- value  out  W  result. Meaningful only while valid≠0, otherwise holds 0.
- busy  out  1  high while a requester is being served (state SERVE).

## Operation
- Reset values:
  - Outputs: valid=0, value=0, busy=0.
  - Internal: state=IDLE, ptr=0 (requester 0 has highest priority), cnt=0, owner=0, latched bound=0.
- Freshness counter cnt:
  - Increments every edge and saturates at GAP.
  - fresh = (cnt==GAP).
  - Consuming rng sets cnt to 0 on that edge.
  - The counter runs in every state.
- **IDLE:**
  - If req≠0, grant the first set bit searching ptr, ptr+1, …, wrapping mod N.
  - Latch owner and bound[owner]. Go to SERVE.
  - Otherwise stay in IDLE.
- **SERVE:**
  - If req[owner]=0 (abandon): go to IDLE. No valid, no consumption, ptr unchanged.
  - Else if !fresh: wait.
  - Else consume: compute cand = rng[W-1:0] & mask.
    - mask = smallest 2^k−1 ≥ bound−1.
    - bound=0 gives all ones. bound=1 gives mask 0.
  - Accept if bound==0 or cand<bound:
    - valid[owner]=1 and value=cand for the next cycle.
    - ptr = (owner+1) mod N. Go to IDLE.
  - Reject otherwise: stay in SERVE and wait for the next fresh word.
- Changes to bound after the grant are ignored until the next grant.
- The abandon check has priority over consumption in the same cycle.
- valid and value are registered. They return to 0 on the edge after the pulse.

## Timing
- Grant occurs on the first edge where state=IDLE and req≠0.
- Consumption occurs on the edge where state=SERVE, fresh, and req[owner]=1. valid and value go high from that edge for exactly one cycle.
- First possible result after reset release: consumption on the GAP-th edge, valid visible during the following cycle.
- Successive valid pulses are at least GAP cycles apart. With continuous requests they are exactly GAP apart, because the grant overlaps with cnt refill.
- Each rejection costs exactly GAP additional cycles.
- Request arrival and abandon in the same cycle by different requesters: grant is computed on current req only.
- Asynchronous reset asserted mid-SERVE clears valid, value and busy immediately without a clock edge. The pending request is lost and the requester must re-request.

## Test plan
- Reset and first draw:
  - Stimulus: hold reset=0 with clk running. Release, set req=3'b001, bound[0]=0, rng=16'h12A5 constant.
  - Response: busy=1 from edge 1. valid=3'b001 with value=8'hA5 on the 16th edge only. Then valid=0, value=0.
- Rejection:
  - Stimulus: req[0]=1, bound[0]=6 (mask 7). rng low byte 0x07 at the first fresh edge, then 0x03.
  - Response: no valid at the first fresh edge. valid[0] with value=3 exactly 16 cycles later.
- Round-robin:
  - Stimulus: req=3'b111 held, all bounds 0.
  - Response: valid sequence 001, 010, 100, 001, with pulses 16 cycles apart, and ptr wraps.
- Degenerate bound:
  - Stimulus: bound=1, rng=16'hFFFF.
  - Response: value=0 on the first fresh edge, no rejection.
- Abandon:
  - Stimulus: req=3'b110. Drop req[1] 5 cycles after its grant.
  - Response: valid[1] never asserts. Requester 2 is granted next. valid[2] occurs 16 edges after reset release (cnt was never cleared).
- Asynchronous reset mid-SERVE:
  - Stimulus: assert reset=0 between edges while busy=1.
  - Response: busy, valid and value are 0 before the next clk edge. After release, behaviour matches the first test.
